// File: rtl/serial_max_driver.sv
// serial_max_driver: word-level front end of the bit-serial max comparator.
// Latches an operand pair, pulses fsm_reset, shifts both words out MSB first,
// deserializes the returned result stream and flags it if it is not max(A,B).
module serial_max_driver #(
    parameter int unsigned W       = 8,
    parameter int unsigned OUT_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         fsm_reset,
    output logic         ai,
    output logic         bi,
    input  logic         fsm_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_err
);

    // Counter spans SHIFT and DRAIN: 0 .. W+OUT_LAT-1, next value up to W+OUT_LAT.
    localparam int unsigned CW = $clog2(W + OUT_LAT + 1);
    localparam logic [CW-1:0] LAST_SHIFT = CW'(W - 1);
    localparam logic [CW-1:0] LAST_BIT   = CW'(W + OUT_LAT - 1);
    localparam logic [CW-1:0] LAT        = CW'(OUT_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StShift,
        StDrain,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_p1;
    logic [W-1:0]  a_q, b_q;
    logic [W-1:0]  a_sh_q, b_sh_q;
    logic [W-1:0]  res_sh_q;
    logic [W-1:0]  max_ab;
    logic          accept;
    logic          capture;

    assign cnt_p1 = cnt_q + CW'(1);
    assign accept = in_valid & in_ready;
    // Result bit for SHIFT cycle k arrives OUT_LAT cycles later; skip the first OUT_LAT.
    assign capture = ((state_q == StShift) || (state_q == StDrain)) && (cnt_p1 > LAT);
    assign max_ab = (a_q >= b_q) ? a_q : b_q;

    // State and bit counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: frame sequencing IDLE -> RST -> SHIFT -> DRAIN -> DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRst;
                    cnt_d   = '0;
                end
            end
            StRst: begin
                state_d = StShift;
            end
            StShift: begin
                cnt_d = cnt_p1;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = (OUT_LAT == 0) ? StDone : StDrain;
                end
            end
            StDrain: begin
                cnt_d = cnt_p1;
                if (cnt_q == LAST_BIT) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Operand latches, transmit shifters and result deserializer.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
        end else begin
            if (accept) begin
                a_q      <= a_in;
                b_q      <= b_in;
                a_sh_q   <= a_in;
                b_sh_q   <= b_in;
                res_sh_q <= '0;
            end else if (state_q == StShift) begin
                a_sh_q <= {a_sh_q[W-2:0], 1'b0};
                b_sh_q <= {b_sh_q[W-2:0], 1'b0};
            end
            if (capture) begin
                res_sh_q <= {res_sh_q[W-2:0], fsm_out};
            end
        end
    end

    // Outputs decoded from state; reset forces the quiescent values immediately.
    always_comb begin
        in_ready  = 1'b0;
        fsm_reset = 1'b1;
        ai        = 1'b0;
        bi        = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        res_err   = 1'b0;
        if (!reset) begin
            in_ready  = (state_q == StIdle);
            fsm_reset = (state_q == StRst);
            if (state_q == StShift) begin
                ai = a_sh_q[W-1];
                bi = b_sh_q[W-1];
            end
            if (state_q == StDone) begin
                res_valid = 1'b1;
                res_data  = res_sh_q;
                res_err   = (res_sh_q != max_ab);
            end
        end
    end

endmodule

// File: tb/tb_serial_max_driver.sv
// tb_serial_max_driver: directed vectors against a behavioural serial max comparator.
module tb_serial_max_driver;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       fsm_reset;
    logic       ai;
    logic       bi;
    logic       fsm_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_err;

    int n_vec = 0;
    int n_err = 0;

    logic       force0;
    logic [1:0] m_st;
    logic       m_out;

    serial_max_driver #(
        .W      (8),
        .OUT_LAT(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .fsm_reset(fsm_reset),
        .ai       (ai),
        .bi       (bi),
        .fsm_out  (fsm_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_err  (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial max comparator: registered output, one cycle latency.
    always @(posedge clk) begin
        if (fsm_reset) begin
            m_st  <= 2'd0;
            m_out <= 1'b0;
        end else begin
            case (m_st)
                2'd0: begin
                    m_out <= ai | bi;
                    if (ai && !bi) m_st <= 2'd1;
                    else if (bi && !ai) m_st <= 2'd2;
                end
                2'd1:    m_out <= ai;
                default: m_out <= bi;
            endcase
        end
    end

    assign fsm_out = force0 ? 1'b0 : m_out;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one frame starting at a negedge; optionally stalls res_ready for hold cycles.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_d,
                             input logic exp_e, input int hold,
                             output logic [7:0] sa, output logic [7:0] sb);
        int t;
        sa = '0;
        sb = '0;
        t  = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        res_ready = (hold == 0);
        a_in      = a;
        b_in      = b;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("fsm_reset_pulse", 32'(fsm_reset), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            sa = {sa[6:0], ai};
            sb = {sb[6:0], bi};
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!res_valid && t < 10);
        check_eq("res_valid", 32'(res_valid), 32'd1);
        check_eq("res_data", 32'(res_data), 32'(exp_d));
        check_eq("res_err", 32'(res_err), 32'(exp_e));
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check_eq("hold_valid", 32'(res_valid), 32'd1);
                check_eq("hold_data", 32'(res_data), 32'(exp_d));
                check_eq("hold_in_ready", 32'(in_ready), 32'd0);
            end
            res_ready = 1'b1;
            @(negedge clk);
            check_eq("release_in_ready", 32'(in_ready), 32'd1);
            check_eq("release_valid", 32'(res_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sa, sb;
        int hits;
        int tv[3];

        reset     = 1'b1;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        force0    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_fsm_reset", 32'(fsm_reset), 32'd1);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_res_data", 32'(res_data), 32'd0);
        check_eq("rst_res_err", 32'(res_err), 32'd0);
        check_eq("rst_ai_bi", 32'({ai, bi}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);
        check_eq("idle_fsm_reset", 32'(fsm_reset), 32'd0);

        // 1: small operands, check serial streams.
        run_frame(8'h07, 8'h1F, 8'h1F, 1'b0, 0, sa, sb);
        check_eq("ai_stream", 32'(sa), 32'h07);
        check_eq("bi_stream", 32'(sb), 32'h1F);

        // 2: first difference at bit 1.
        run_frame(8'hB5, 8'hB7, 8'hB7, 1'b0, 0, sa, sb);
        check_eq("ai_stream2", 32'(sa), 32'hB5);

        // 3: equal operands.
        run_frame(8'hFF, 8'hFF, 8'hFF, 1'b0, 0, sa, sb);
        run_frame(8'h00, 8'h00, 8'h00, 1'b0, 0, sa, sb);

        // 4: consumer stalls five cycles in DONE.
        run_frame(8'h80, 8'h7F, 8'h80, 1'b0, 5, sa, sb);

        // 5: reset mid-frame after three SHIFT bits.
        while (!in_ready) @(negedge clk);
        a_in     = 8'hC3;
        b_in     = 8'h3C;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
        check_eq("midrst_fsm_reset", 32'(fsm_reset), 32'd1);
        check_eq("midrst_ai_bi", 32'({ai, bi}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("postrst_in_ready", 32'(in_ready), 32'd1);
        hits = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (res_valid) hits++;
        end
        check_eq("postrst_no_valid", 32'(hits), 32'd0);
        run_frame(8'h1F, 8'h07, 8'h1F, 1'b0, 0, sa, sb);

        // 6: back-to-back frames with in_valid held.
        while (!in_ready) @(negedge clk);
        a_in     = 8'h5A;
        b_in     = 8'h3C;
        in_valid = 1'b1;
        hits     = 0;
        tv[0]    = -100;
        tv[1]    = -200;
        tv[2]    = -300;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (res_valid) begin
                check_eq("b2b_data", 32'(res_data), 32'h5A);
                if (hits < 3) tv[hits] = c;
                hits++;
            end
        end
        in_valid = 1'b0;
        check_eq("b2b_period1", 32'(tv[1] - tv[0]), 32'd12);
        check_eq("b2b_period2", 32'(tv[2] - tv[1]), 32'd12);

        // 6b: stuck-at-0 result stream is flagged.
        force0 = 1'b1;
        run_frame(8'h3C, 8'h5A, 8'h00, 1'b1, 0, sa, sb);
        force0 = 1'b0;
        run_frame(8'h3C, 8'h5A, 8'h5A, 1'b0, 0, sa, sb);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
